list_walker: RTL and testbench

Bus initiator that traverses a singly linked list in the RAM on the PicoRV32-style native memory interface (mem_valid/mem_ready), and writes the result back. Each node's data words are summed and nodes are counted. The block sits beside the CPU as a second bus master and drives the memory controller directly. It plays the initiator role that the CPU otherwise fills.

---
 rtl/list_walker.sv | 180 ++++++++++++++++++
 tb/tb_list_walker.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/list_walker.sv
// Second bus master that walks a singly linked list over the native memory
// interface, sums the node data words, counts nodes and writes both back.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; done/error hold the last outcome
// GAP     | one idle bus cycle, then issue the request held in pend
// RD_DATA | reading node data word at ptr
// RD_NEXT | reading next pointer at ptr+4
// WR_SUM  | writing sum to result_addr
// WR_CNT  | writing count to result_addr+4
module list_walker #(
    parameter int WIDTH     = 32,
    parameter int MAX_NODES = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] head_addr,
    input  logic [WIDTH-1:0] result_addr,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] count,
    output logic             mem_valid,
    output logic             mem_instr,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_RD_DATA,
        S_RD_NEXT,
        S_WR_SUM,
        S_WR_CNT
    } state_t;

    localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MAX_NODES);
    localparam logic [WIDTH-1:0] WORD_OFS = WIDTH'(4);

    state_t           state;
    state_t           pend;
    logic [WIDTH-1:0] ptr;
    logic [WIDTH-1:0] res_ptr;
    logic             hs;

    assign hs        = mem_valid & mem_ready;
    assign mem_instr = 1'b0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            pend      <= S_IDLE;
            ptr       <= '0;
            res_ptr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            sum       <= '0;
            count     <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= 4'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr     <= head_addr;
                        res_ptr <= result_addr;
                        sum     <= '0;
                        count   <= '0;
                        done    <= 1'b0;
                        error   <= 1'b0;
                        if (head_addr[1:0] != 2'b00) begin
                            // misaligned head: fail without touching the bus
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            busy  <= 1'b1;
                            state <= S_GAP;
                            pend  <= (head_addr == '0) ? S_WR_SUM : S_RD_DATA;
                        end
                    end
                end

                S_GAP: begin
                    mem_valid <= 1'b1;
                    state     <= pend;
                    case (pend)
                        S_RD_DATA: begin
                            mem_addr  <= ptr;
                            mem_wstrb <= 4'h0;
                        end
                        S_RD_NEXT: begin
                            mem_addr  <= ptr + WORD_OFS;
                            mem_wstrb <= 4'h0;
                        end
                        S_WR_SUM: begin
                            mem_addr  <= res_ptr;
                            mem_wdata <= sum;
                            mem_wstrb <= 4'hF;
                        end
                        S_WR_CNT: begin
                            mem_addr  <= res_ptr + WORD_OFS;
                            mem_wdata <= count;
                            mem_wstrb <= 4'hF;
                        end
                        default: begin
                            mem_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    endcase
                end

                S_RD_DATA: begin
                    if (hs) begin
                        sum       <= sum + mem_rdata;
                        count     <= count + WIDTH'(1);
                        mem_valid <= 1'b0;
                        state     <= S_GAP;
                        pend      <= S_RD_NEXT;
                    end
                end

                S_RD_NEXT: begin
                    if (hs) begin
                        ptr       <= mem_rdata;
                        mem_valid <= 1'b0;
                        if (mem_rdata == '0) begin
                            state <= S_GAP;
                            pend  <= S_WR_SUM;
                        end else if ((mem_rdata[1:0] != 2'b00) || (count == MAX_CNT)) begin
                            // bad pointer or node limit reached: abort, no result writes
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            state <= S_GAP;
                            pend  <= S_RD_DATA;
                        end
                    end
                end

                S_WR_SUM: begin
                    if (hs) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= 4'h0;
                        state     <= S_GAP;
                        pend      <= S_WR_CNT;
                    end
                end

                S_WR_CNT: begin
                    if (hs) begin
                        mem_valid <= 1'b0;
                        mem_wstrb <= 4'h0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    mem_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_list_walker.sv
// Directed bench for list_walker: word RAM responder with optional wait
// states, a list-walking reference model and a per-cycle compare process.
module tb_list_walker;

    localparam int MAXN = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        start = 1'b0;
    logic [31:0] head_addr = '0;
    logic [31:0] result_addr = '0;
    logic        busy, done, error;
    logic [31:0] sum, count;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    list_walker #(.WIDTH(32), .MAX_NODES(MAXN)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .head_addr(head_addr), .result_addr(result_addr),
        .busy(busy), .done(done), .error(error), .sum(sum), .count(count),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // word RAM responder
    logic [31:0] ram_w [0:1023];
    logic [1:0]  wait_cnt = 2'd0;
    bit          rand_en = 1'b0;

    assign mem_ready = mem_valid && (wait_cnt == 2'd0);
    assign mem_rdata = ram_w[mem_addr[11:2]];

    always @(posedge clk) begin
        if (!mem_valid)
            wait_cnt <= rand_en ? 2'($urandom_range(0, 3)) : 2'd0;
        else if (wait_cnt != 2'd0)
            wait_cnt <= wait_cnt - 2'd1;
        if (mem_valid && mem_ready && mem_wstrb == 4'hF)
            ram_w[mem_addr[11:2]] <= mem_wdata;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string act, input string exp);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %s, want %s", name, act, exp);
    endtask

    // reference model: expected transaction list with running sum/count after each
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] psum;
        logic [31:0] pcnt;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] exp_sum, exp_cnt, fin_sum, fin_cnt;
    bit          exp_err, fin;
    bit          chk_en = 1'b0;
    int          hs_cnt;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return ram_w[a[11:2]];
    endfunction

    task automatic push(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                        input logic [31:0] s, input logic [31:0] n);
        txn_t t;
        t.addr = a; t.wstrb = ws; t.wdata = wd; t.psum = s; t.pcnt = n;
        exp_q.push_back(t);
    endtask

    task automatic build_expect(input logic [31:0] head, input logic [31:0] res);
        logic [31:0] p, nx, s, n;
        exp_q.delete();
        s = 0; n = 0; exp_err = 0;
        if (head[1:0] != 2'b00) begin
            exp_err = 1; fin_sum = 0; fin_cnt = 0;
            return;
        end
        p = head;
        while (p != 0) begin
            s = s + rd(p);
            n = n + 1;
            push(p, 4'h0, 32'h0, s, n);
            nx = rd(p + 32'd4);
            push(p + 32'd4, 4'h0, 32'h0, s, n);
            if (nx != 0 && (nx[1:0] != 2'b00 || n == MAXN)) begin
                exp_err = 1; fin_sum = s; fin_cnt = n;
                return;
            end
            p = nx;
        end
        push(res, 4'hF, s, s, n);
        push(res + 32'd4, 4'hF, n, s, n);
        fin_sum = s; fin_cnt = n;
    endtask

    // compare process
    bit          prev_hs, prev_stall;
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wstrb;

    always @(negedge clk) begin
        if (!chk_en) begin
            prev_hs = 0;
            prev_stall = 0;
        end else begin
            chk("run_sum", sum, exp_sum);
            chk("run_count", count, exp_cnt);
            chk("run_busy", busy, !fin);
            chk("run_done", done, fin && !exp_err);
            chk("run_error", error, fin && exp_err);
            chk("mem_instr", mem_instr, 0);
            if (prev_hs) chk("gap_valid", mem_valid, 0);
            if (prev_stall) begin
                chk("stall_valid", mem_valid, 1);
                chk("stall_addr", mem_addr, p_addr);
                chk("stall_wstrb", mem_wstrb, p_wstrb);
                chk("stall_wdata", mem_wdata, p_wdata);
            end
            if (mem_valid && mem_ready) begin
                txn_t t;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    fail_now("extra_txn", $sformatf("txn at 0x%08h", mem_addr), "no txn");
                end else begin
                    t = exp_q.pop_front();
                    chk("txn_addr", mem_addr, t.addr);
                    chk("txn_wstrb", mem_wstrb, t.wstrb);
                    if (t.wstrb != 4'h0) chk("txn_wdata", mem_wdata, t.wdata);
                    exp_sum = t.psum;
                    exp_cnt = t.pcnt;
                    if (exp_q.size() == 0) fin = 1;
                end
            end
            prev_hs    = mem_valid && mem_ready;
            prev_stall = mem_valid && !mem_ready;
            p_addr     = mem_addr;
            p_wstrb    = mem_wstrb;
            p_wdata    = mem_wdata;
        end
    end

    task automatic clear_ram();
        for (int i = 0; i < 1024; i++) ram_w[i] = 32'h0;
    endtask

    task automatic put(input logic [31:0] a, input logic [31:0] v);
        ram_w[a[11:2]] = v;
    endtask

    task automatic three_node();
        clear_ram();
        put(32'h100, 5); put(32'h104, 32'h200);
        put(32'h200, 7); put(32'h204, 32'h300);
        put(32'h300, 9); put(32'h304, 32'h0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_valid"}, mem_valid, 0);
        chk({tag, "_wstrb"}, mem_wstrb, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_instr"}, mem_instr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_sum"}, sum, 0);
        chk({tag, "_count"}, count, 0);
    endtask

    task automatic run_walk(input logic [31:0] head, input logic [31:0] res,
                            input bit rnd, input bit pulse, input string tag,
                            output int cyc_o);
        int cyc, ntx;
        build_expect(head, res);
        ntx = exp_q.size();
        rand_en = rnd;
        @(negedge clk);
        head_addr = head;
        result_addr = res;
        start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        hs_cnt = 0;
        exp_sum = 0;
        exp_cnt = 0;
        fin = (ntx == 0);
        chk_en = 1;
        cyc = 0;
        while (!(done || error) && cyc < 2000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (pulse && cyc == 5) begin start = 1; head_addr = 32'h500; end
            if (pulse && cyc == 6) begin start = 0; head_addr = head; end
        end
        start = 0;
        if (!(done || error))
            fail_now({tag, "_timeout"}, "no done/error in 2000 cycles", "done or error");
        chk_en = 0;
        chk({tag, "_done"}, done, !exp_err);
        chk({tag, "_error"}, error, exp_err);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sum"}, sum, fin_sum);
        chk({tag, "_count"}, count, fin_cnt);
        chk({tag, "_left"}, exp_q.size(), 0);
        if (!rnd) chk({tag, "_cycles"}, cyc, 2 * ntx);
        if (!exp_err) begin
            chk({tag, "_ram_sum"}, rd(res), fin_sum);
            chk({tag, "_ram_cnt"}, rd(res + 32'd4), fin_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "_quiet"}, mem_valid, 0);
        end
        cyc_o = cyc;
    endtask

    initial begin
        int cyc;
        bit found;
        clear_ram();
        #2 resetn = 0;
        #1 check_reset_vals("por");
        repeat (2) @(negedge clk);
        resetn = 1;

        // 3-node list, zero wait
        three_node();
        run_walk(32'h100, 32'h400, 0, 0, "t3n", cyc);
        chk("t3n_lit_sum", rd(32'h400), 21);
        chk("t3n_lit_cnt", rd(32'h404), 3);
        chk("t3n_lit_cyc", cyc, 16);
        chk("t3n_lit_txns", hs_cnt, 8);

        // empty list: two writes only
        put(32'h410, 32'hDEAD_BEEF); put(32'h414, 32'hCAFE_F00D);
        run_walk(32'h0, 32'h410, 0, 0, "empty", cyc);
        chk("empty_lit_ram0", rd(32'h410), 0);
        chk("empty_lit_ram1", rd(32'h414), 0);
        chk("empty_lit_txns", hs_cnt, 2);

        // empty list with result address wrapping past 2^32
        put(32'hFFFF_FFFC, 32'h1234); put(32'h0, 32'h5678);
        run_walk(32'h0, 32'hFFFF_FFFC, 0, 0, "reswrap", cyc);

        // sum wraps modulo 2^32
        clear_ram();
        put(32'h800, 32'hFFFF_FFFF); put(32'h804, 32'h810);
        put(32'h810, 32'h2);         put(32'h814, 32'h0);
        run_walk(32'h800, 32'h900, 0, 0, "wrap", cyc);
        chk("wrap_lit_sum", sum, 32'h1);
        chk("wrap_lit_cnt", count, 2);

        // self loop hits the node limit
        clear_ram();
        put(32'h500, 3); put(32'h504, 32'h500);
        run_walk(32'h500, 32'h400, 0, 0, "loop", cyc);
        chk("loop_lit_err", error, 1);
        chk("loop_lit_cnt", count, 4);
        chk("loop_lit_sum", sum, 12);
        chk("loop_lit_txns", hs_cnt, 8);
        chk("loop_lit_nowr", rd(32'h400), 0);

        // exactly MAXN nodes completes; MAXN+1 aborts
        clear_ram();
        put(32'h600, 1); put(32'h604, 32'h610);
        put(32'h610, 2); put(32'h614, 32'h620);
        put(32'h620, 3); put(32'h624, 32'h630);
        put(32'h630, 4); put(32'h634, 32'h0);
        run_walk(32'h600, 32'h400, 0, 0, "max4", cyc);
        chk("max4_lit_done", done, 1);
        chk("max4_lit_sum", rd(32'h400), 10);
        put(32'h634, 32'h640); put(32'h640, 5); put(32'h644, 32'h0);
        put(32'h400, 0); put(32'h404, 0);
        run_walk(32'h600, 32'h400, 0, 0, "max5", cyc);
        chk("max5_lit_err", error, 1);
        chk("max5_lit_cnt", count, 4);

        // misaligned head and misaligned next pointer
        run_walk(32'h102, 32'h400, 0, 0, "badhead", cyc);
        chk("badhead_lit_txns", hs_cnt, 0);
        chk("badhead_lit_cyc", cyc, 0);
        clear_ram();
        put(32'h700, 8); put(32'h704, 32'h206);
        run_walk(32'h700, 32'h400, 0, 0, "badnext", cyc);
        chk("badnext_lit_cyc", cyc, 4);
        chk("badnext_lit_sum", sum, 8);

        // random wait states
        for (int r = 0; r < 3; r++) begin
            three_node();
            run_walk(32'h100, 32'h400, 1, 0, $sformatf("rnd%0d", r), cyc);
            chk($sformatf("rnd%0d_lit_sum", r), rd(32'h400), 21);
            chk($sformatf("rnd%0d_lit_cnt", r), rd(32'h404), 3);
        end
        rand_en = 0;

        // reset during RD_NEXT, then a fresh walk
        three_node();
        @(negedge clk);
        head_addr = 32'h100; result_addr = 32'h400; start = 1;
        @(posedge clk);
        @(negedge clk);
        start = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mem_valid && mem_addr == 32'h104) found = 1;
            else @(negedge clk);
        end
        if (!found) fail_now("rst_reach_rdnext", "not reached", "RD_NEXT request");
        #2 resetn = 0;
        #1 check_reset_vals("midrst");
        @(negedge clk);
        resetn = 1;
        chk("midrst_nowr", rd(32'h400), 0);
        run_walk(32'h100, 32'h400, 0, 0, "after_rst", cyc);
        chk("after_rst_lit_cyc", cyc, 16);

        // start pulse while busy is ignored
        three_node();
        put(32'h500, 100); put(32'h504, 32'h0);
        run_walk(32'h100, 32'h400, 0, 1, "busy_start", cyc);
        chk("busy_start_lit_sum", rd(32'h400), 21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
